// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Holds the PC, issues one instruction-memory read
//   at a time over a valid/ready request channel, accepts a variable-latency
//   response and buffers one instruction for the decoder (instr[31:21] feeds
//   the main decoder's Op input). A taken-branch redirect reloads the PC and
//   discards whatever fetch is in flight.
//
// Parameters
//   N         PC / address width
//   RESET_PC  PC loaded on reset (word aligned)
//
// Ports
//   clk             in   rising-edge clock
//   reset_n         in   asynchronous active-low reset
//   fetch_en        in   allow new fetches to start (gates leaving IDLE/FULL)
//   redirect_valid  in   branch taken this cycle
//   redirect_pc     in   branch target, bits [1:0] ignored
//   imem_req_valid  out  read request valid
//   imem_req_ready  in   memory accepts the request this cycle
//   imem_addr       out  read address (always the current pc)
//   imem_rsp_valid  in   read data valid
//   imem_rsp_data   in   instruction word
//   instr_valid     out  instr / instr_pc hold a valid instruction
//   instr_ready     in   consumer takes the instruction this cycle
//   instr           out  buffered instruction
//   instr_pc        out  address of instr
//
// State  | meaning
// -------+------------------------------------------------------------------
// IDLE   | nothing outstanding, waiting for fetch_en
// REQ    | request asserted at pc, waiting for imem_req_ready
// WAIT   | request accepted, waiting for the response to keep
// DRAIN  | request accepted but redirected; next response is thrown away
// FULL   | one instruction buffered, waiting for instr_ready
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter int           N        = 64,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         fetch_en,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [N-1:0] imem_addr,
    input  logic         imem_rsp_valid,
    input  logic [31:0]  imem_rsp_data,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [31:0]  instr,
    output logic [N-1:0] instr_pc
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        FULL  = 3'd4
    } state_t;

    state_t       state;
    logic [N-1:0] pc;
    logic [N-1:0] pc_inc;
    logic [N-1:0] redirect_tgt;
    logic         unused_redirect_lsbs;

    // Targets are word aligned; the low two bits of the branch target are dropped.
    assign redirect_tgt         = {redirect_pc[N-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Wraps naturally modulo 2^N.
    assign pc_inc = pc + {{(N-3){1'b0}}, 3'd4};

    // The address is the pc register itself, so it only moves on an accepted
    // response or a redirect and stays put while a request waits for ready.
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            imem_req_valid <= 1'b0;
            instr_valid    <= 1'b0;
            instr          <= '0;
            instr_pc       <= RESET_PC;
        end else begin
            // Redirect always wins for the pc; the WAIT response path below
            // only advances pc when no redirect is present.
            if (redirect_valid) begin
                pc <= redirect_tgt;
            end

            case (state)
                IDLE: begin
                    // A redirect in IDLE only retargets; fetching starts a cycle later.
                    if (!redirect_valid && fetch_en) begin
                        state          <= REQ;
                        imem_req_valid <= 1'b1;
                    end
                end

                REQ: begin
                    // fetch_en is deliberately ignored here: an asserted
                    // request is never withdrawn.
                    if (imem_req_ready) begin
                        imem_req_valid <= 1'b0;
                        state          <= redirect_valid ? DRAIN : WAIT;
                    end
                end

                WAIT: begin
                    if (redirect_valid) begin
                        if (imem_rsp_valid) begin
                            // Stale response lands on the redirect cycle:
                            // drop it and go straight to the new target.
                            state          <= REQ;
                            imem_req_valid <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (imem_rsp_valid) begin
                        instr       <= imem_rsp_data;
                        instr_pc    <= pc;
                        pc          <= pc_inc;
                        instr_valid <= 1'b1;
                        state       <= FULL;
                    end
                end

                DRAIN: begin
                    // The outstanding response belongs to the abandoned path.
                    if (imem_rsp_valid) begin
                        if (fetch_en) begin
                            state          <= REQ;
                            imem_req_valid <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                FULL: begin
                    // With redirect and instr_ready together the consumer has
                    // already taken the instruction this cycle; either way the
                    // buffer empties and fetch resumes from the (possibly new) pc.
                    if (redirect_valid || instr_ready) begin
                        instr_valid <= 1'b0;
                        if (fetch_en) begin
                            state          <= REQ;
                            imem_req_valid <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state          <= IDLE;
                    imem_req_valid <= 1'b0;
                    instr_valid    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. A background process plays instruction
//   memory (configurable response latency, data derived from the address) and
//   the instruction consumer. Expected request addresses and expected
//   delivered instruction PCs are queued when each step is set up and popped
//   as the DUT produces them.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int          N      = 64;
    localparam logic [63:0] RST_PC = 64'h100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;

    int          vectors = 0;
    int          errs    = 0;
    int          mem_lat = 0;

    logic [63:0] exp_addr_q[$];
    logic [63:0] exp_pc_q[$];

    logic        pend;
    int          cnt;
    logic [63:0] paddr;
    logic [63:0] e_pc;

    fetch_unit #(.N(N), .RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_accept(input int max, input string tag);
        int   i = 0;
        logic to;
        while (!(imem_req_valid && imem_req_ready) && i < max) begin
            @(negedge clk);
            i++;
        end
        to = (i >= max);
        chk({tag, "_timeout"}, 64'(to), 64'd0);
    endtask

    task automatic wait_valid(input int max, input string tag);
        int   i = 0;
        logic to;
        while (!instr_valid && i < max) begin
            @(negedge clk);
            i++;
        end
        to = (i >= max);
        chk({tag, "_timeout"}, 64'(to), 64'd0);
    endtask

    // Runs until every queued request and delivery has been seen; fetch_en is
    // dropped once the last expected request is out so the DUT parks in IDLE.
    task automatic run_drained(input int max, input string tag);
        int   i = 0;
        logic to;
        while ((exp_addr_q.size() != 0 || exp_pc_q.size() != 0) && i < max) begin
            if (exp_addr_q.size() == 0) fetch_en = 1'b0;
            @(negedge clk);
            i++;
        end
        fetch_en = 1'b0;
        to = (i >= max);
        chk({tag, "_timeout"}, 64'(to), 64'd0);
    endtask

    // Memory model and consumer monitor; inputs settle at negedge, this looks
    // 2 time units later so handshakes reflect what the next posedge will see.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        pend           = 1'b0;
        cnt            = 0;
        paddr          = '0;
        forever begin
            @(negedge clk);
            #2;
            imem_rsp_valid = 1'b0;
            if (!reset_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (cnt == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = mem_word(paddr);
                        pend           = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    if (exp_addr_q.size() == 0) begin
                        vectors++;
                        errs++;
                        $error("FAIL req_unexpected observed addr=%h expected no request", imem_addr);
                    end else begin
                        chk("req_addr", imem_addr, exp_addr_q.pop_front());
                    end
                    pend  = 1'b1;
                    cnt   = mem_lat;
                    paddr = imem_addr;
                end
                if (instr_valid && instr_ready) begin
                    if (exp_pc_q.size() == 0) begin
                        vectors++;
                        errs++;
                        $error("FAIL instr_unexpected observed pc=%h expected no transfer", instr_pc);
                    end else begin
                        e_pc = exp_pc_q.pop_front();
                        chk("instr_pc", instr_pc, e_pc);
                        chk("instr", 64'(instr), 64'(mem_word(e_pc)));
                    end
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b1;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        mem_lat        = 0;

        // Reset values
        #2 reset_n = 1'b0;
        #1;
        chk("rst_req_valid",   64'(imem_req_valid), 64'd0);
        chk("rst_addr",        imem_addr,           RST_PC);
        chk("rst_instr_valid", 64'(instr_valid),    64'd0);
        chk("rst_instr",       64'(instr),          64'd0);
        chk("rst_instr_pc",    instr_pc,            RST_PC);
        tick(2);

        // 1: sequential zero-wait fetches from RESET_PC
        exp_addr_q.push_back(64'h100); exp_addr_q.push_back(64'h104); exp_addr_q.push_back(64'h108);
        exp_pc_q.push_back(64'h100);   exp_pc_q.push_back(64'h104);   exp_pc_q.push_back(64'h108);
        fetch_en = 1'b1;
        reset_n  = 1'b1;
        run_drained(60, "t1");
        tick(3);
        chk("t1_idle_req",   64'(imem_req_valid), 64'd0);
        chk("t1_idle_valid", 64'(instr_valid),    64'd0);
        chk("t1_next_addr",  imem_addr,           64'h10C);

        // 2: slow response, consumer stalls; buffer holds and no new request
        mem_lat     = 5;
        instr_ready = 1'b0;
        exp_addr_q.push_back(64'h10C);
        exp_pc_q.push_back(64'h10C);
        fetch_en = 1'b1;
        wait_accept(10, "t2_acc");
        tick();
        wait_valid(20, "t2_valid");
        for (int k = 0; k < 4; k++) begin
            chk("t2_hold_valid", 64'(instr_valid),    64'd1);
            chk("t2_hold_pc",    instr_pc,            64'h10C);
            chk("t2_hold_instr", 64'(instr),          64'(mem_word(64'h10C)));
            chk("t2_no_req",     64'(imem_req_valid), 64'd0);
            tick();
        end
        fetch_en    = 1'b0;
        instr_ready = 1'b1;
        tick(2);
        chk("t2_drained_valid", 64'(instr_valid), 64'd0);
        chk("t2_pc_q_empty",    64'(exp_pc_q.size()), 64'd0);

        // 3: redirect while WAIT; old response discarded, refetch at 0x200
        mem_lat = 3;
        exp_addr_q.push_back(64'h110); exp_addr_q.push_back(64'h200);
        exp_pc_q.push_back(64'h200);
        fetch_en = 1'b1;
        wait_accept(10, "t3_acc");
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h203;
        tick();
        redirect_valid = 1'b0;
        chk("t3_drain_req",  64'(imem_req_valid), 64'd0);
        chk("t3_drain_addr", imem_addr,           64'h200);
        chk("t3_drain_valid", 64'(instr_valid),   64'd0);
        run_drained(60, "t3");
        tick(2);
        chk("t3_last_pc",   instr_pc,  64'h200);
        chk("t3_next_addr", imem_addr, 64'h204);

        // 4: redirect in FULL with instr_ready=1; consumed exactly once
        mem_lat     = 0;
        instr_ready = 1'b0;
        exp_addr_q.push_back(64'h204);
        exp_pc_q.push_back(64'h204);
        fetch_en = 1'b1;
        wait_valid(20, "t4_valid");
        exp_addr_q.push_back(64'h400);
        exp_pc_q.push_back(64'h400);
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h400;
        tick();
        redirect_valid = 1'b0;
        chk("t4_valid_drop", 64'(instr_valid),    64'd0);
        chk("t4_req",        64'(imem_req_valid), 64'd1);
        chk("t4_addr",       imem_addr,           64'h400);
        run_drained(40, "t4");
        tick(2);

        // 4b: redirect in FULL without instr_ready; buffered instr is dropped
        instr_ready = 1'b0;
        exp_addr_q.push_back(64'h404);
        fetch_en = 1'b1;
        wait_valid(20, "t4b_valid");
        exp_addr_q.push_back(64'h500);
        exp_pc_q.push_back(64'h500);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h501;
        tick();
        redirect_valid = 1'b0;
        chk("t4b_valid_drop", 64'(instr_valid), 64'd0);
        chk("t4b_addr",       imem_addr,        64'h500);
        instr_ready = 1'b1;
        run_drained(40, "t4b");
        tick(2);

        // 5: PC wrap at 2^N-4; redirect in IDLE stays IDLE for that cycle
        mem_lat = 1;
        exp_addr_q.push_back(64'hFFFF_FFFF_FFFF_FFFC); exp_addr_q.push_back(64'h0);
        exp_pc_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);   exp_pc_q.push_back(64'h0);
        fetch_en       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        chk("t5_idle_req",  64'(imem_req_valid), 64'd0);
        chk("t5_idle_addr", imem_addr,           64'hFFFF_FFFF_FFFF_FFFC);
        run_drained(40, "t5");
        tick(2);
        chk("t5_wrap_addr", imem_addr, 64'h4);

        // 6: reset during WAIT; outputs reset immediately, resume at RESET_PC
        mem_lat = 8;
        exp_addr_q.push_back(64'h4);
        fetch_en = 1'b1;
        wait_accept(10, "t6_acc");
        tick(2);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_req",   64'(imem_req_valid), 64'd0);
        chk("t6_rst_addr",  imem_addr,           RST_PC);
        chk("t6_rst_valid", 64'(instr_valid),    64'd0);
        chk("t6_rst_instr", 64'(instr),          64'd0);
        chk("t6_rst_pc",    instr_pc,            RST_PC);
        tick();
        mem_lat = 0;
        exp_addr_q.push_back(64'h100);
        exp_pc_q.push_back(64'h100);
        reset_n = 1'b1;
        run_drained(40, "t6");
        tick(3);
        chk("t6_next_addr", imem_addr, 64'h104);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
